// File: rtl/dvp_cam_source.sv
// dvp_cam_source
//   OV5640-style DVP transmitter producing RGB565 (high byte first), one byte
//   per clk. Stands in for a physical sensor when bringing up the capture path.
//
// Ports
//   clk        byte clock (forwarded as pixel clock by the instantiating level)
//   rst        synchronous reset, active-high
//   enable     level; starts streaming, deassertion stops at the frame end
//   pattern    0 colour bars, 1 x+y ramp, 2 solid, 3 frame-tagged
//   solid_rgb  RGB565 value for pattern 2
//   cam_vsync  frame sync, active-high, for the first VSYNC_LINES lines
//   cam_href   high during active bytes
//   cam_data   pixel byte, 0 outside href
//   busy       high while a frame is in progress
//   frame_done one-clk pulse on the last clk of each frame
//   frame_cnt  frames completed since reset (wraps)
//
// All outputs are registered from the h/v counters, so they lag the counters
// by one clk.
module dvp_cam_source #(
  parameter int H_ACTIVE    = 512,
  parameter int V_ACTIVE    = 768,
  parameter int H_TOTAL     = 2240,
  parameter int H_START     = 16,
  parameter int V_TOTAL     = 1272,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int HW     = $clog2(H_TOTAL);
  localparam int VW     = $clog2(V_TOTAL);
  localparam int BAR_PX = H_ACTIVE / 8;
  localparam int BW     = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FIRST_ACT = HW'(H_START);
  localparam logic [HW-1:0] H_LAST_ACT  = HW'(H_START + 2 * H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC_LINES);
  localparam logic [VW-1:0] V_FIRST_ACT = VW'(VSYNC_LINES + V_BACK);
  localparam logic [VW-1:0] V_LAST_ACT  = VW'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST    = BW'(BAR_PX - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Per-frame snapshot of the control inputs
  logic [1:0]  pat_q;
  logic [15:0] solid_q;
  logic [15:0] tag_q;

  // Colour-bar reload counter: pixels left in the current bar and bar index
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;

  logic          run, start, line_end, frame_end, relatch;
  logic          act_line, act_byte, odd_byte;
  logic [HW-1:0] h_off;
  logic [15:0]   x, y, bar_rgb, pixel;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = (state == RUN);
    start     = 1'b0;
    line_end  = run && (h_cnt == H_LAST);
    frame_end = line_end && (v_cnt == V_LAST);
    case (state)
      IDLE: if (enable) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN: if (frame_end && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A new frame begins either from idle or back-to-back after the last one
    relatch = start || (frame_end && enable);
  end

  // ------------------------------------------------------ pixel position
  always_comb begin
    act_line = (v_cnt >= V_FIRST_ACT) && (v_cnt <= V_LAST_ACT);
    act_byte = run && act_line && (h_cnt >= H_FIRST_ACT) && (h_cnt <= H_LAST_ACT);
    h_off    = h_cnt - H_FIRST_ACT;
    odd_byte = h_off[0];
    x        = 16'(h_off[HW-1:1]);
    y        = 16'(v_cnt - V_FIRST_ACT);
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  always_comb begin
    case (pat_q)
      2'd0:    pixel = bar_rgb;
      2'd1:    pixel = x + y;
      2'd2:    pixel = solid_q;
      default: pixel = {tag_q[7:0], x[7:0]};
    endcase
  end

  // ------------------------------------------------------------ counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      tag_q   <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (relatch) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pat_q   <= pattern;
      solid_q <= solid_rgb;
      // frame_cnt is bumped on this same edge when chaining frames
      tag_q   <= start ? frame_cnt : frame_cnt + 16'd1;
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (run) begin
      if (line_end) begin
        h_cnt   <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        bar_px  <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + HW'(1);
        // Advance after the low byte of each pixel
        if (act_byte && odd_byte) begin
          if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_px <= bar_px + BW'(1);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      cam_vsync  <= run && (v_cnt < V_SYNC_END);
      cam_href   <= act_byte;
      cam_data   <= act_byte ? (odd_byte ? pixel[7:0] : pixel[15:8]) : 8'h00;
      busy       <= run;
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
